// File: rtl/stage_sequencer_pkg.sv
// Shared definitions for the instruction-cycle sequencer: state encoding,
// write-back mask bit positions and default sizing.
package stage_sequencer_pkg;

  localparam int unsigned WORD               = 16;
  localparam int unsigned WB_TIMEOUT_DEFAULT = 8;

  // Pending-mask layout shared by the FSM and the write-back tracker.
  localparam int unsigned WB_NUM  = 3;
  localparam int unsigned WB_REG  = 0;
  localparam int unsigned WB_MEM  = 1;
  localparam int unsigned WB_FLAG = 2;

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StFetch   = 4'd1,
    StReg     = 4'd2,
    StExec    = 4'd3,
    StWbIssue = 4'd4,
    StWbWait  = 4'd5,
    StPcWb    = 4'd6,
    StHalted  = 4'd7,
    StError   = 4'd8
  } state_e;

  // Isolates the lowest set bit; this fixes the reg -> mem -> flag order.
  function automatic logic [WB_NUM-1:0] lowest_bit(input logic [WB_NUM-1:0] mask);
    return mask & (~mask + WB_NUM'(1));
  endfunction

endpackage

// File: rtl/stage_sequencer_if.sv
// Handshake bundle between the sequencer and the rest of the CPU.
// master: the sequencer; slave: the datapath/control environment around it.
interface stage_sequencer_if
  import stage_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W = WORD
) ();

  logic             run;
  logic             halt_req;
  logic             reg_write_en;
  logic             mem_write_en;
  logic             flag_update_en;
  logic             reg_wb_done;
  logic             mem_wb_done;
  logic             flag_wb_done;
  logic             fetch_tr;
  logic             reg_tr;
  logic             dne_tr;
  logic             reg_wb_tr;
  logic             mem_wb_tr;
  logic             flag_update_tr;
  logic             PC_wb_tr;
  logic             busy;
  logic             halted;
  logic             wb_error;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  run, halt_req, reg_write_en, mem_write_en, flag_update_en,
           reg_wb_done, mem_wb_done, flag_wb_done,
    output fetch_tr, reg_tr, dne_tr, reg_wb_tr, mem_wb_tr, flag_update_tr, PC_wb_tr,
           busy, halted, wb_error, cycle_count, instr_count
  );

  modport slave (
    output run, halt_req, reg_write_en, mem_write_en, flag_update_en,
           reg_wb_done, mem_wb_done, flag_wb_done,
    input  fetch_tr, reg_tr, dne_tr, reg_wb_tr, mem_wb_tr, flag_update_tr, PC_wb_tr,
           busy, halted, wb_error, cycle_count, instr_count
  );

endinterface

// File: rtl/stage_sequencer_wb_tracker.sv
// Write-back tracker: holds the pending mask, clears bits on their done acks,
// runs the write-back timeout and generates the write-back strobes.
// Optional macro STAGE_SERIAL_WB_EN: issue write-backs one at a time in
// reg -> mem -> flag order, restarting the timeout for each one.
module stage_sequencer_wb_tracker
  import stage_sequencer_pkg::*;
#(
  parameter int unsigned WB_TIMEOUT = WB_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue,
  input  logic              in_wait,
  input  logic [WB_NUM-1:0] en,
  input  logic [WB_NUM-1:0] done,
  output logic [WB_NUM-1:0] strobe,
  output logic              all_done,
  output logic              timeout
);

  localparam int unsigned TmoW = $clog2(WB_TIMEOUT + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(WB_TIMEOUT - 1);

  logic [WB_NUM-1:0] pending_q, pending_d;
  logic [WB_NUM-1:0] accept;
  logic [WB_NUM-1:0] remaining;
  logic [TmoW-1:0]   tmo_q, tmo_d;
`ifdef STAGE_SERIAL_WB_EN
  logic              issue_q, issue_d;
`endif

  // Next pending mask, timeout count and strobes.
  always_comb begin
    pending_d = pending_q;
    tmo_d     = tmo_q;
    strobe    = '0;
    all_done  = 1'b0;
    timeout   = 1'b0;
`ifdef STAGE_SERIAL_WB_EN
    issue_d   = 1'b0;
    // Only the write-back in flight may complete; other dones are stray.
    accept    = pending_q & done & lowest_bit(pending_q);
`else
    accept    = pending_q & done;
`endif
    remaining = pending_q & ~accept;

    if (issue) begin
      pending_d = en;
      tmo_d     = '0;
`ifdef STAGE_SERIAL_WB_EN
      strobe    = lowest_bit(en);
`else
      strobe    = en;
`endif
    end else if (in_wait) begin
      pending_d = remaining;
      all_done  = (remaining == '0);
`ifdef STAGE_SERIAL_WB_EN
      // Next write-back goes out the cycle after the previous one completed.
      if (issue_q) begin
        strobe = lowest_bit(pending_q);
      end
      if (accept != '0) begin
        tmo_d   = '0;
        issue_d = !all_done;
      end else if (tmo_q == TmoLast) begin
        timeout = 1'b1;
      end else begin
        tmo_d = tmo_q + TmoW'(1);
      end
`else
      if (!all_done) begin
        if (tmo_q == TmoLast) begin
          timeout = 1'b1;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
`endif
    end
  end

  // Tracker state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      tmo_q     <= '0;
    end else begin
      pending_q <= pending_d;
      tmo_q     <= tmo_d;
    end
  end

`ifdef STAGE_SERIAL_WB_EN
  // Serial-issue request flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      issue_q <= 1'b0;
    end else begin
      issue_q <= issue_d;
    end
  end
`endif

endmodule

// File: rtl/stage_sequencer.sv
// Instruction-cycle controller: one FSM stepping fetch, register read,
// decode/execute, write-back and PC update, with run/halt control,
// write-back timeout and cycle/instruction counters.
// Optional macro STAGE_SERIAL_WB_EN selects serial write-back issue.
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int unsigned WB_TIMEOUT = WB_TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W      = WORD
) (
  input logic               clk,
  input logic               reset,
  stage_sequencer_if.master bus
);

  state_e            state_q, state_d;
  logic              halt_q, halt_d;
  logic [CNT_W-1:0]  cycle_q;
  logic [CNT_W-1:0]  instr_q;
  logic [WB_NUM-1:0] wb_en;
  logic [WB_NUM-1:0] wb_done;
  logic [WB_NUM-1:0] wb_strobe;
  logic              wb_issue;
  logic              wb_wait;
  logic              wb_all_done;
  logic              wb_timeout;
  logic              fetch_stb;
  logic              reg_stb;
  logic              dne_stb;
  logic              pc_stb;
  logic              busy;

  assign wb_en   = {bus.flag_update_en, bus.mem_write_en, bus.reg_write_en};
  assign wb_done = {bus.flag_wb_done, bus.mem_wb_done, bus.reg_wb_done};

  assign wb_issue = (state_q == StWbIssue);
  assign wb_wait  = (state_q == StWbWait);

  stage_sequencer_wb_tracker #(
    .WB_TIMEOUT(WB_TIMEOUT)
  ) u_wb_tracker (
    .clk     (clk),
    .reset   (reset),
    .issue   (wb_issue),
    .in_wait (wb_wait),
    .en      (wb_en),
    .done    (wb_done),
    .strobe  (wb_strobe),
    .all_done(wb_all_done),
    .timeout (wb_timeout)
  );

  // Next-state, halt latch and stage strobes.
  always_comb begin
    state_d   = state_q;
    halt_d    = halt_q;
    fetch_stb = 1'b0;
    reg_stb   = 1'b0;
    dne_stb   = 1'b0;
    pc_stb    = 1'b0;

    if (state_q != StIdle && bus.halt_req) begin
      halt_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.run) state_d = StFetch;
      end
      StFetch: begin
        fetch_stb = 1'b1;
        state_d   = StReg;
      end
      StReg: begin
        reg_stb = 1'b1;
        state_d = StExec;
      end
      StExec: begin
        dne_stb = 1'b1;
        state_d = StWbIssue;
      end
      StWbIssue: begin
        state_d = (wb_en == '0) ? StPcWb : StWbWait;
      end
      StWbWait: begin
        if (wb_all_done) begin
          state_d = StPcWb;
        end else if (wb_timeout) begin
          state_d = StError;
        end
      end
      StPcWb: begin
        pc_stb = 1'b1;
        if (halt_q) begin
          state_d = StHalted;
          // A request landing on this boundary applies to the next one.
          halt_d  = bus.halt_req;
        end else begin
          state_d = StFetch;
        end
      end
      StHalted: begin
        if (bus.run) state_d = StFetch;
      end
      StError: begin
        state_d = StError;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM state and halt latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
    end
  end

  assign busy = !(state_q inside {StIdle, StHalted, StError});

  // Active-cycle counter saturates; retired-instruction counter wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      if (busy && cycle_q != '1) cycle_q <= cycle_q + CNT_W'(1);
      if (pc_stb) instr_q <= instr_q + CNT_W'(1);
    end
  end

  assign bus.fetch_tr       = fetch_stb;
  assign bus.reg_tr         = reg_stb;
  assign bus.dne_tr         = dne_stb;
  assign bus.reg_wb_tr      = wb_strobe[WB_REG];
  assign bus.mem_wb_tr      = wb_strobe[WB_MEM];
  assign bus.flag_update_tr = wb_strobe[WB_FLAG];
  assign bus.PC_wb_tr       = pc_stb;
  assign bus.busy           = busy;
  assign bus.halted         = (state_q == StHalted);
  assign bus.wb_error       = (state_q == StError);
  assign bus.cycle_count    = cycle_q;
  assign bus.instr_count    = instr_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer. The reference model builds each
// instruction's expected strobe timeline from the stage/write-back rules.
module tb_stage_sequencer;

  localparam int unsigned Tmo  = 8;
  localparam int unsigned CntW = 16;
`ifdef STAGE_SERIAL_WB_EN
  localparam bit Serial = 1'b1;
`else
  localparam bit Serial = 1'b0;
`endif

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   exp_instr;
  int   exp_cyc;
  bit   halt_pend;
  logic [2:0] stb_s [0:63];
  logic [2:0] dn_s  [0:63];
  logic [2:0] nz_s  [0:63];

  stage_sequencer_if #(.CNT_W(CntW)) bus ();

  stage_sequencer #(
    .WB_TIMEOUT(Tmo),
    .CNT_W     (CntW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {busy, halted, wb_error, fetch, reg, dne, flag_wb, mem_wb, reg_wb, pc_wb}
  function automatic logic [9:0] obs();
    return {bus.busy, bus.halted, bus.wb_error, bus.fetch_tr, bus.reg_tr, bus.dne_tr,
            bus.flag_update_tr, bus.mem_wb_tr, bus.reg_wb_tr, bus.PC_wb_tr};
  endfunction

  function automatic logic [9:0] mk(input logic busy, input logic hlt, input logic err,
                                    input logic f, input logic r, input logic d,
                                    input logic [2:0] wb, input logic pc);
    return {busy, hlt, err, f, r, d, wb[2], wb[1], wb[0], pc};
  endfunction

  task automatic drive(input logic run, input logic halt, input logic [2:0] en,
                       input logic [2:0] dn);
    bus.run            = run;
    bus.halt_req       = halt;
    bus.reg_write_en   = en[0];
    bus.mem_write_en   = en[1];
    bus.flag_update_en = en[2];
    bus.reg_wb_done    = dn[0];
    bus.mem_wb_done    = dn[1];
    bus.flag_wb_done   = dn[2];
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 1'b0, 3'b000, 3'b000);
    @(negedge clk);
    reset     = 1'b0;
    exp_instr = 0;
    exp_cyc   = 0;
    halt_pend = 1'b0;
  endtask

  // One idle/halted cycle with run raised; the next cycle must be FETCH.
  task automatic start(input logic from_halt);
    @(negedge clk);
    drive(1'b1, 1'b0, 3'($urandom), 3'($urandom));
    #1;
    checks++;
    if (obs() !== mk(1'b0, from_halt, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0)) begin
      errors++;
      $display("FAIL start: got %b want %b", obs(), mk(1'b0, from_halt, 1'b0, 1'b0, 1'b0,
               1'b0, 3'b000, 1'b0));
    end
  endtask

  // Runs one instruction; d0..d2 are done delays (cycles after each strobe).
  task automatic run_instr(input logic [2:0] en, input int d0, input int d1, input int d2,
                           input int halt_cyc, output bit went_halt);
    int d[3];
    int st[3];
    int dt[3];
    int w_len;
    int t;
    int len;
    logic [9:0] e;
    logic [2:0] wb;
    logic [2:0] dn;
    d[0] = d0;
    d[1] = d1;
    d[2] = d2;
    for (int w = 0; w < 64; w++) begin
      stb_s[w] = 3'b000;
      dn_s[w]  = 3'b000;
      nz_s[w]  = 3'b000;
    end
    w_len = 0;
    t     = 0;
    for (int i = 0; i < 3; i++) begin
      st[i] = 0;
      dt[i] = 0;
      if (en[i]) begin
        if (Serial) begin
          st[i] = t;
          dt[i] = t + d[i];
          t     = dt[i] + 1;
        end else begin
          dt[i] = d[i];
        end
        stb_s[st[i]][i] = 1'b1;
        dn_s[dt[i]][i]  = 1'b1;
        if (dt[i] > w_len) w_len = dt[i];
      end
    end
    // Dones that must be ignored: not requested, already done, or not yet in flight.
    for (int w = 1; w <= w_len; w++) begin
      for (int i = 0; i < 3; i++) begin
        if (!en[i] || w > dt[i] || (Serial && w < st[i])) nz_s[w][i] = 1'b1;
      end
    end
    len       = 5 + w_len;
    went_halt = 1'b0;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      dn = 3'($urandom) & 3'($urandom);
      if (c >= 4 && c <= len - 2) dn = dn_s[c-3] | (nz_s[c-3] & dn);
      else if (c >= 3) dn = 3'b000;
      drive(1'($urandom), (c == halt_cyc), (c == 3) ? en : 3'($urandom), dn);
      #1;
      wb = (c >= 3 && c <= len - 2) ? stb_s[c-3] : 3'b000;
      e  = mk(1'b1, 1'b0, 1'b0, c == 0, c == 1, c == 2, wb, c == len - 1);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL instr%0d en=%b c=%0d: got %b want %b", exp_instr, en, c, obs(), e);
      end
      if (c == 0) begin
        checks++;
        if (bus.instr_count !== CntW'(exp_instr) || bus.cycle_count !== CntW'(exp_cyc)) begin
          errors++;
          $display("FAIL counts@fetch: got instr=%0d cyc=%0d want instr=%0d cyc=%0d",
                   bus.instr_count, bus.cycle_count, exp_instr, exp_cyc);
        end
      end
      exp_cyc++;
      if (c == len - 1) begin
        went_halt = halt_pend;
        halt_pend = (c == halt_cyc);
      end else if (c == halt_cyc) begin
        halt_pend = 1'b1;
      end
    end
    exp_instr++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 1'b1, 3'b111, 3'b111);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (obs() !== 10'b0 || bus.cycle_count !== '0 || bus.instr_count !== '0) begin
      errors++;
      $display("FAIL reset_held: got %b cyc=%0d instr=%0d want all zero", obs(),
               bus.cycle_count, bus.instr_count);
    end
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 3'b000);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (obs() !== 10'b0) begin
        errors++;
        $display("FAIL idle_no_run: got %b want 0", obs());
      end
    end
    exp_instr = 0;
    exp_cyc   = 0;
    halt_pend = 1'b0;
  endtask

  task automatic test_no_wb();
    bit wh;
    apply_reset();
    start(1'b0);
    run_instr(3'b000, 0, 0, 0, -1, wh);
    run_instr(3'b000, 0, 0, 0, -1, wh);
    @(negedge clk);
    drive(1'b0, 1'b0, 3'b000, 3'b000);
    #1;
    checks++;
    if (bus.instr_count !== CntW'(2) || bus.cycle_count !== CntW'(10)) begin
      errors++;
      $display("FAIL no_wb_counts: got instr=%0d cyc=%0d want instr=2 cyc=10",
               bus.instr_count, bus.cycle_count);
    end
  endtask

  task automatic test_concurrent();
    bit wh;
    apply_reset();
    start(1'b0);
    run_instr(3'b011, 1, 1, 0, -1, wh);
    run_instr(3'b101, 3, 0, Tmo, -1, wh);
    run_instr(3'b000, 0, 0, 0, -1, wh);
  endtask

  task automatic test_timeout();
    logic [9:0] e;
    apply_reset();
    start(1'b0);
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      drive(1'($urandom), (c >= 12) ? 1'($urandom) : 1'b0,
            (c == 3) ? 3'b100 : 3'($urandom),
            (c >= 12) ? 3'($urandom) : ((c >= 4) ? (3'($urandom) & 3'b011) : 3'b000));
      #1;
      if (c < 12) e = mk(1'b1, 1'b0, 1'b0, c == 0, c == 1, c == 2,
                         (c == 3) ? 3'b100 : 3'b000, 1'b0);
      else        e = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL timeout c=%0d: got %b want %b", c, obs(), e);
      end
    end
    checks++;
    if (bus.instr_count !== CntW'(0) || bus.cycle_count !== CntW'(12)) begin
      errors++;
      $display("FAIL timeout_counts: got instr=%0d cyc=%0d want instr=0 cyc=12",
               bus.instr_count, bus.cycle_count);
    end
    apply_reset();
    #1;
    checks++;
    if (obs() !== 10'b0 || bus.cycle_count !== '0) begin
      errors++;
      $display("FAIL error_cleared: got %b cyc=%0d want 0", obs(), bus.cycle_count);
    end
  endtask

  task automatic test_halt();
    bit wh;
    apply_reset();
    // A halt request while idle must be forgotten.
    @(negedge clk);
    drive(1'b0, 1'b1, 3'b000, 3'b000);
    #1;
    checks++;
    if (obs() !== 10'b0) begin
      errors++;
      $display("FAIL halt_in_idle: got %b want 0", obs());
    end
    start(1'b0);
    run_instr(3'b000, 0, 0, 0, -1, wh);
    run_instr(3'b010, 2, 2, 0, 1, wh);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 3'($urandom), 3'($urandom));
      #1;
      checks++;
      if (obs() !== mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0) ||
          bus.instr_count !== CntW'(exp_instr) || bus.cycle_count !== CntW'(exp_cyc)) begin
        errors++;
        $display("FAIL halted%0d: got %b instr=%0d cyc=%0d want halted instr=%0d cyc=%0d",
                 i, obs(), bus.instr_count, bus.cycle_count, exp_instr, exp_cyc);
      end
    end
    start(1'b1);
    // Halt on the PC_WB boundary defers to the next instruction.
    run_instr(3'b000, 0, 0, 0, 4, wh);
    run_instr(3'b001, 1, 0, 0, -1, wh);
    @(negedge clk);
    drive(1'b0, 1'b0, 3'b000, 3'b000);
    #1;
    checks++;
    if (obs() !== mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0)) begin
      errors++;
      $display("FAIL deferred_halt: got %b want halted", obs());
    end
  endtask

  task automatic test_reset_mid_wb();
    logic [9:0] e;
    apply_reset();
    start(1'b0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 5) reset = 1'b1;
      drive(1'b0, 1'b0, (c == 3) ? 3'b010 : 3'b000, 3'b000);
      #1;
      e = mk(1'b1, 1'b0, 1'b0, c == 0, c == 1, c == 2, (c == 3) ? 3'b010 : 3'b000, 1'b0);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL pre_abort c=%0d: got %b want %b", c, obs(), e);
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      reset = 1'b0;
      drive(1'b0, 1'b0, 3'b000, (i == 0) ? 3'b010 : 3'b000);
      #1;
      checks++;
      if (obs() !== 10'b0 || bus.cycle_count !== '0 || bus.instr_count !== '0) begin
        errors++;
        $display("FAIL post_abort%0d: got %b cyc=%0d instr=%0d want all zero", i, obs(),
                 bus.cycle_count, bus.instr_count);
      end
    end
  endtask

  task automatic test_serial_order();
    bit wh;
    apply_reset();
    start(1'b0);
    run_instr(3'b111, 1, 1, 1, -1, wh);
    run_instr(3'b111, 2, Tmo, 1, -1, wh);
    run_instr(3'b110, 1, 3, 2, -1, wh);
  endtask

  task automatic test_back_to_back();
    bit wh;
    int dd[3];
    apply_reset();
    start(1'b0);
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 3; i++) begin
        dd[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, Tmo) : $urandom_range(1, 2);
      end
      run_instr(3'($urandom), dd[0], dd[1], dd[2], -1, wh);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 3'b000, 3'b000);
    #1;
    checks++;
    if (bus.instr_count !== CntW'(exp_instr) || bus.cycle_count !== CntW'(exp_cyc)) begin
      errors++;
      $display("FAIL b2b_counts: got instr=%0d cyc=%0d want instr=%0d cyc=%0d",
               bus.instr_count, bus.cycle_count, exp_instr, exp_cyc);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    drive(1'b0, 1'b0, 3'b000, 3'b000);
    test_reset();
    test_no_wb();
    test_concurrent();
    test_timeout();
    test_halt();
    test_reset_mid_wb();
    test_serial_order();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
